serial_adder: RTL

- Bit-serial adder for WIDTH-bit operands with carry-in, built on one full_adder instance (positional ports x, y, z, s, c) and a registered carry.
- Adds one bit per clock, LSB first, and returns a WIDTH-bit sum and carry-out after WIDTH cycles.
- Sits directly downstream of full_adder: it is the sequential stage that consumes the full_adder s/c outputs, serving datapaths where area matters more than latency.

---
 rtl/serial_adder.sv | 99 +++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clk, LSB first, through a single full adder.
// Latency: start accepted at edge E0 -> done high after edge E(WIDTH); next start accepted at E(WIDTH+2) earliest.
// Backpressure: none; start is only sampled in IDLE, and start in RUN/DONE is dropped (no queuing).

module full_adder (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);
    // one-bit sum and carry
    assign s = x ^ y ^ z;
    assign c = (x & y) | (z & (x ^ y));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    // cnt reaches WIDTH-1 on the last shift; WIDTH itself would not fit in CW bits
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;

    // the single bit-slice: current LSBs of both operands plus the carry from the previous bit
    full_adder u_fa (a_sh[0], b_sh[0], carry, fa_s, fa_c);

    // control FSM and datapath: load on accept, shift one bit per cycle in RUN, one-cycle DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // result bits enter at the MSB and drift down, so after WIDTH shifts bit 0 lands at sum[0]
                    sum   <= {fa_s, sum[WIDTH-1:1]};
                    carry <= fa_c;
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        cout  <= fa_c;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // status flags decoded straight from the state register
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
